// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage bus between the pipeline and the multiply/divide unit.
//   master (pipeline side): drives en, md_op, rs_val, rt_val, d_is_md;
//                           observes busy, stall_md, md_out, hi, lo.
//   slave  (unit side):     the reverse directions.
interface mdu_sequencer_if;
    logic        en;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output en, md_op, rs_val, rt_val, d_is_md,
        input  busy, stall_md, md_out, hi, lo
    );

    modport slave (
        input  en, md_op, rs_val, rt_val, d_is_md,
        output busy, stall_md, md_out, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide unit with its own sequencer; owns HI/LO.
//   clk   : clock
//   reset : synchronous, active-high reset
//   md    : slave side of mdu_sequencer_if
//           en/md_op/rs_val/rt_val - E-stage operation and operands
//           d_is_md                - D-stage instruction is MD-class
//           busy                   - multi-cycle operation in progress
//           stall_md               - freeze request to the hazard unit
//           md_out                 - HI for mfhi, LO for mflo, else 0
//           hi/lo                  - current architectural HI/LO
// Results are computed when the operation starts and held in pending
// registers; HI/LO only change when the fixed latency has elapsed.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mdu_sequencer_if.slave md
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic        busy, is_mult, is_div, start;
    logic [63:0] prod;
    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b, dvsr, q_u, r_u, q_res, r_res;

    assign busy    = (state_q == StRun);
    assign is_mult = (md.md_op == OpMult) || (md.md_op == OpMultu);
    assign is_div  = (md.md_op == OpDiv) || (md.md_op == OpDivu);
    assign start   = md.en && !busy && (is_mult || is_div);

    // Arithmetic on the live operands; only captured on a start.
    always_comb begin
        // Sign-extending both operands makes the low 64 bits of an unsigned
        // multiply equal to the signed product.
        prod = {{32{(md.md_op == OpMult) & md.rs_val[31]}}, md.rs_val} *
               {{32{(md.md_op == OpMult) & md.rt_val[31]}}, md.rt_val};
        neg_a = (md.md_op == OpDiv) && md.rs_val[31];
        neg_b = (md.md_op == OpDiv) && md.rt_val[31];
        abs_a = neg_a ? -md.rs_val : md.rs_val;
        abs_b = neg_b ? -md.rt_val : md.rt_val;
        // Divide-by-zero results are discarded; avoid a zero divisor anyway.
        dvsr  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_u   = abs_a / dvsr;
        r_u   = abs_a % dvsr;
        q_res = (neg_a ^ neg_b) ? -q_u : q_u;
        r_res = neg_a ? -r_u : r_u;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    if (is_mult) begin
                        cnt_d     = CntW'(MULT_CYCLES);
                        pend_hi_d = prod[63:32];
                        pend_lo_d = prod[31:0];
                        pend_wr_d = 1'b1;
                    end else begin
                        cnt_d     = CntW'(DIV_CYCLES);
                        pend_hi_d = r_res;
                        pend_lo_d = q_res;
                        pend_wr_d = (md.rt_val != 32'd0);
                    end
                end else if (md.en && md.md_op == OpMthi) begin
                    hi_d = md.rs_val;
                end else if (md.en && md.md_op == OpMtlo) begin
                    lo_d = md.rs_val;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d   = StIdle;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        md.md_out = 32'd0;
        if (md.en && md.md_op == OpMfhi) md.md_out = hi_q;
        if (md.en && md.md_op == OpMflo) md.md_out = lo_q;
    end

    // Holding D while a start issues keeps a dependent MD op from slipping in.
    assign md.stall_md = md.d_is_md && (busy || start);
    assign md.busy     = busy;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule
